// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt, answering LSU loads/stores.
// Optional: define BUS_TIMER_RELOAD_EN to enable CTRL.reload (auto-clear mtime on compare hit).
module bus_timer #(
  parameter int PRESCALE_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ce_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [1:0]  hb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        dbg_state_o
);

  // Handshake: an access is taken on the edge where IDLE sees req_i & ce_i;
  // gnt_o is high for exactly the following cycle (ACK), then back to IDLE.
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t state_q, state_d;

  logic [63:0]           mtime_q, mtime_d, cmp_q;
  logic [31:0]           shadow_q;
  logic [PRESCALE_W-1:0] prescale_q, pcnt_q, pcnt_d;
  logic                  en_q, irq_en_q, pending_q;
  logic                  reload_bit;
  logic                  access, wr, rd, tick, hit, w1c;
  logic [1:0]            lane;
  logic [2:0]            reg_sel;
  logic [7:0]            wr_sel;
  logic [3:0]            wmask;
  logic [31:0]           wdat, rsel, rshift, rload, ctrl_rd, ctrl_w, prescale_w;
  logic                  unused_bits;

`ifdef BUS_TIMER_RELOAD_EN
  logic reload_q;
  assign reload_bit = reload_q;
`else
  assign reload_bit = 1'b0;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m,
                                        input logic [31:0] d);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && ce_i) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign access      = (state_q == IDLE) && req_i && ce_i;
  assign wr          = access && we_i;
  assign rd          = access && !we_i;
  assign lane        = addr_i[1:0];
  assign reg_sel     = addr_i[4:2];
  assign wr_sel      = wr ? (8'b1 << reg_sel) : 8'h00;
  assign gnt_o       = (state_q == ACK);
  assign dbg_state_o = (state_q == ACK);
  assign irq_o       = pending_q & irq_en_q;

  // Store lanes and data aligned onto the 32-bit register image.
  always_comb begin
    wmask = 4'b0000;
    wdat  = 32'h0;
    case (hb_i)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wdat  = {24'h0, wdata_i[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        wmask = 4'b0011 << {lane[1], 1'b0};
        wdat  = {16'h0, wdata_i[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        wmask = 4'b1111;
        wdat  = wdata_i;
      end
    endcase
  end

  assign ctrl_rd    = {29'h0, reload_bit, irq_en_q, en_q};
  assign ctrl_w     = merge(ctrl_rd, wmask, wdat);
  assign prescale_w = merge(32'(prescale_q), wmask, wdat);
  assign w1c        = wr_sel[5] && wmask[0] && wdat[0];

  always_comb begin
    rsel = 32'h0;
    case (reg_sel)
      3'd0:    rsel = mtime_q[31:0];
      3'd1:    rsel = shadow_q;
      3'd2:    rsel = cmp_q[31:0];
      3'd3:    rsel = cmp_q[63:32];
      3'd4:    rsel = ctrl_rd;
      3'd5:    rsel = {31'h0, pending_q};
      3'd6:    rsel = 32'(prescale_q);
      default: rsel = 32'h0;
    endcase
    rshift = rsel >> {lane, 3'b000};
    case (hb_i)
      2'b00:   rload = {24'h0, rshift[7:0]};
      2'b01:   rload = {16'h0, rshift[15:0]};
      default: rload = rshift;
    endcase
  end

  // Prescaler uses >= so a PRESCALE lowered below a frozen count still wraps at once.
  always_comb begin
    tick   = 1'b0;
    pcnt_d = pcnt_q;
    if (en_q) begin
      if (pcnt_q >= prescale_q) begin
        pcnt_d = '0;
        tick   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PRESCALE_W'(1);
      end
    end
    hit     = (mtime_q >= cmp_q);
    mtime_d = mtime_q;
    if (tick) mtime_d = mtime_q + 64'd1;
`ifdef BUS_TIMER_RELOAD_EN
    if (tick && reload_q && hit) mtime_d = 64'd0;
`endif
    // A bus write drops any tick: the untouched half keeps its value, no carry.
    if (wr_sel[0])      mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wmask, wdat)};
    else if (wr_sel[1]) mtime_d = {merge(mtime_q[63:32], wmask, wdat), mtime_q[31:0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mtime_q    <= 64'd0;
      cmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q   <= 32'h0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      rdata_o    <= 32'h0;
`ifdef BUS_TIMER_RELOAD_EN
      reload_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mtime_q   <= mtime_d;
      pcnt_q    <= pcnt_d;
      pending_q <= hit | (pending_q & ~w1c);
      if (wr_sel[2]) cmp_q[31:0]  <= merge(cmp_q[31:0], wmask, wdat);
      if (wr_sel[3]) cmp_q[63:32] <= merge(cmp_q[63:32], wmask, wdat);
      if (wr_sel[4]) begin
        en_q     <= ctrl_w[0];
        irq_en_q <= ctrl_w[1];
`ifdef BUS_TIMER_RELOAD_EN
        reload_q <= ctrl_w[2];
`endif
      end
      if (wr_sel[6]) prescale_q <= prescale_w[PRESCALE_W-1:0];
      if (rd) begin
        rdata_o <= rload;
        if (reg_sel == 3'd0) shadow_q <= mtime_q[63:32];
      end
    end
  end

  assign unused_bits = ^{addr_i[31:5], ctrl_w[31:2], prescale_w[31:PRESCALE_W], wr_sel[7]};

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: bus driver tasks, expected-read queue, summary report.
module tb_bus_timer;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        ce_i    = 1'b0;
  logic        req_i   = 1'b0;
  logic        we_i    = 1'b0;
  logic [1:0]  hb_i    = 2'b00;
  logic [31:0] addr_i  = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        gnt_o, irq_o, dbg_state_o;
  logic [31:0] rdata_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic        irq_at_gnt;
  logic [31:0] dummy, got, rnd;

  always #5 clk_i = ~clk_i;

  bus_timer #(.PRESCALE_W(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ce_i        (ce_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .we_i        (we_i),
    .hb_i        (hb_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .irq_o       (irq_o),
    .dbg_state_o (dbg_state_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus access; grant must arrive one cycle after the request and last one cycle.
  task automatic bus_xfer(input logic w, input logic [1:0] hb, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd);
    int cyc;
    @(negedge clk_i);
    check("gnt_idle", gnt_o, 1'b0);
    ce_i = 1'b1; req_i = 1'b1; we_i = w; hb_i = hb; addr_i = a; wdata_i = d;
    @(posedge clk_i); #1;
    ce_i = 1'b0; req_i = 1'b0; we_i = 1'b0; wdata_i = 32'h0;
    cyc = 1;
    while (gnt_o !== 1'b1 && cyc < 4) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("gnt_latency", cyc, 1);
    irq_at_gnt = irq_o;
    rd = rdata_o;
    @(posedge clk_i); #1;
    check("gnt_pulse", gnt_o, 1'b0);
  endtask

  task automatic bus_write(input logic [1:0] hb, input logic [31:0] a, input logic [31:0] d);
    bus_xfer(1'b1, hb, a, d, dummy);
  endtask

  task automatic read_expect(input string tag, input logic [1:0] hb, input logic [31:0] a,
                             input logic [31:0] exp);
    logic [31:0] obs;
    exp_q.push_back(exp);
    bus_xfer(1'b0, hb, a, 32'h0, obs);
    check(tag, obs, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] reset_exp [8];
    reset_exp = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_gnt", gnt_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_irq", irq_o, 1'b0);
    check("rst_state", dbg_state_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) read_expect("rst_reg", 2'b10, 32'(i * 4), reset_exp[i]);

    // Prescaler: PRESCALE=3 gives one tick per 4 clocks
    bus_write(2'b10, 32'h18, 32'd3);
    bus_write(2'b10, 32'h10, 32'd1);
    repeat (40) @(posedge clk_i);
    bus_xfer(1'b0, 2'b10, 32'h00, 32'h0, got);
    check("prescale_mtime", (got >= 32'd9) && (got <= 32'd11), 1'b1);
    bus_write(2'b10, 32'h10, 32'd0);

    // Atomic 64-bit read across the 32-bit carry
    bus_write(2'b10, 32'h18, 32'd0);
    bus_write(2'b10, 32'h00, 32'hFFFF_FFFE);
    bus_write(2'b10, 32'h04, 32'h0);
    bus_write(2'b10, 32'h10, 32'd1);
    read_expect("atomic_lo0", 2'b10, 32'h00, 32'hFFFF_FFFF);
    read_expect("atomic_hi0", 2'b10, 32'h04, 32'h0000_0000);
    read_expect("atomic_lo1", 2'b10, 32'h00, 32'h0000_0003);
    read_expect("atomic_hi1", 2'b10, 32'h04, 32'h0000_0001);
    bus_write(2'b10, 32'h10, 32'd0);

    // Compare and interrupt
    bus_write(2'b10, 32'h00, 32'd0);
    bus_write(2'b10, 32'h04, 32'd0);
    bus_write(2'b10, 32'h0C, 32'd0);
    bus_write(2'b10, 32'h08, 32'd20);
    bus_write(2'b10, 32'h10, 32'd2);
    check("irq_idle", irq_o, 1'b0);
    read_expect("status_idle", 2'b10, 32'h14, 32'h0);
    bus_write(2'b10, 32'h00, 32'd20);
    check("irq_at_gnt", irq_at_gnt, 1'b0);
    check("irq_rise", irq_o, 1'b1);
    bus_write(2'b10, 32'h14, 32'd1);
    check("irq_w1c_hit", irq_o, 1'b1);
    read_expect("status_set", 2'b10, 32'h14, 32'h1);
    bus_write(2'b10, 32'h10, 32'd0);
    check("irq_en_off", irq_o, 1'b0);
    bus_write(2'b10, 32'h10, 32'd2);
    check("irq_en_on", irq_o, 1'b1);
    bus_write(2'b10, 32'h08, 32'hFFFF_FFFF);
    bus_write(2'b10, 32'h0C, 32'hFFFF_FFFF);
    check("irq_sticky", irq_o, 1'b1);
    bus_write(2'b10, 32'h14, 32'd1);
    check("irq_cleared", irq_o, 1'b0);
    read_expect("status_clr", 2'b10, 32'h14, 32'h0);

    // Byte/half/word lanes
    bus_write(2'b00, 32'h09, 32'h0000_00AB);
    read_expect("cmp_byte_w", 2'b10, 32'h08, 32'hFFFF_ABFF);
    read_expect("cmp_half_r", 2'b01, 32'h0A, 32'h0000_FFFF);
    read_expect("cmp_byte_r", 2'b00, 32'h09, 32'h0000_00AB);
    bus_write(2'b01, 32'h0B, 32'h5555_1234);
    read_expect("cmp_half_w", 2'b10, 32'h08, 32'h1234_ABFF);
    read_expect("cmp_byte3", 2'b00, 32'h0B, 32'h0000_0012);
    bus_write(2'b11, 32'h0A, 32'hCAFE_F00D);
    read_expect("cmp_word_w", 2'b10, 32'h08, 32'hCAFE_F00D);
    bus_write(2'b10, 32'h1C, 32'd5);
    check("rdata_hold", rdata_o, 32'hCAFE_F00D);
    read_expect("reserved", 2'b10, 32'h1C, 32'h0);

    // CTRL readback and random PRESCALE round trips
    bus_write(2'b10, 32'h10, 32'd7);
`ifdef BUS_TIMER_RELOAD_EN
    read_expect("ctrl_rb", 2'b10, 32'h10, 32'd7);
`else
    read_expect("ctrl_rb", 2'b10, 32'h10, 32'd3);
`endif
    for (int i = 0; i < 4; i++) begin
      rnd = $urandom_range(32'hFFFF_FFFF, 0);
      bus_write(2'b10, 32'h18, rnd);
      read_expect("prescale_rb", 2'b10, 32'h18, {16'h0, rnd[15:0]});
    end

`ifdef BUS_TIMER_RELOAD_EN
    // Periodic reload: mtime stays within 0..CMP
    bus_write(2'b10, 32'h10, 32'd0);
    bus_write(2'b10, 32'h18, 32'd0);
    bus_write(2'b10, 32'h00, 32'd0);
    bus_write(2'b10, 32'h04, 32'd0);
    bus_write(2'b10, 32'h0C, 32'd0);
    bus_write(2'b10, 32'h08, 32'd4);
    bus_write(2'b10, 32'h10, 32'd7);
    for (int i = 0; i < 6; i++) begin
      bus_xfer(1'b0, 2'b10, 32'h00, 32'h0, got);
      check("reload_range", got <= 32'd4, 1'b1);
    end
    check("reload_irq", irq_o, 1'b1);
`endif

    // Reset in the middle of an access: no grant
    @(negedge clk_i);
    ce_i = 1'b1; req_i = 1'b1; we_i = 1'b0; hb_i = 2'b10; addr_i = 32'h08;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    ce_i = 1'b0; req_i = 1'b0;
    #1;
    check("midrst_gnt", gnt_o, 1'b0);
    check("midrst_state", dbg_state_o, 1'b0);
    check("midrst_rdata", rdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    read_expect("midrst_cmp", 2'b10, 32'h08, 32'hFFFF_FFFF);
    read_expect("midrst_ctrl", 2'b10, 32'h10, 32'h0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
